// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: sends ALU responses on a serial line as 11-bit frames
// (start 0, type bit, 8 payload bits MSB first, stop 1), one bit per clk.
//   data response : 4 DATA frames (result bytes, MSB byte first) + 1 CTL frame
//                   with payload {0, flags, crc3}
//   error response: 1 CTL frame with payload {1, err_flags, err_flags, parity}
// Build option: define MTM_ALU_SER_GAP_EN to insert two idle-high GAP cycles
// between consecutive frames of one response. Default build: frames are
// back-to-back and GAP is never entered.
//
// Handshake: a request is accepted on a rising edge where start_data or
// start_err is high, rst is low, and the block is free -- ready=1, or the
// final stop bit of the current response is on the line (this lets a new
// response chain onto the old one with no idle cycle). Inputs are latched on
// the accept edge. Requests at any other time are dropped, never queued.
// start_err wins over start_data when both are high.
module mtm_alu_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_data,
   input  logic        start_err,
   input  logic [31:0] result,
   input  logic [3:0]  flags,
   input  logic [2:0]  err_flags,
   output logic        ready,
   output logic        sout
);

   typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, GAP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;     // bit within frame (0..10), or GAP cycle
   logic [2:0]  frame_cnt_q, frame_cnt_d; // frame within response (0..4)
   logic [31:0] result_q, result_d;
   logic [3:0]  flags_q, flags_d;
   logic [2:0]  err_q, err_d;
   logic [2:0]  crc_q, crc_d;
   logic        is_err_q, is_err_d;
   logic        sout_q, sout_d;
   logic        ready_q, ready_d;
   logic        accept;
   logic        last_frame;
   logic        last_stop;
   logic        type_bit;
   logic [7:0]  payload;

   // CRC-3, poly x^3+x+1, init 0, over {result, 1'b0, flags} MSB first.
   function automatic logic [2:0] crc3(input logic [31:0] r, input logic [3:0] f);
      logic [36:0] msg;
      logic [2:0]  c;
      logic        fb;
      msg = {r, 1'b0, f};
      c   = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb = c[2] ^ msg[i];
         c  = {c[1], c[0] ^ fb, fb};
      end
      return c;
   endfunction

   assign last_frame = is_err_q ? (frame_cnt_q == 3'd0) : (frame_cnt_q == 3'd4);
   assign last_stop  = (state_q == FRAME) && (bit_cnt_q == 4'd10) && last_frame;
   assign accept     = !rst && (start_data || start_err) && (ready_q || last_stop);

   // State register: FSM state, position counters, latched request, outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 4'd0;
         frame_cnt_q <= 3'd0;
         result_q    <= 32'd0;
         flags_q     <= 4'd0;
         err_q       <= 3'd0;
         crc_q       <= 3'd0;
         is_err_q    <= 1'b0;
         sout_q      <= 1'b1;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
         crc_q       <= crc_d;
         is_err_q    <= is_err_d;
         sout_q      <= sout_d;
         ready_q     <= ready_d;
      end
   end

   // Next-state logic: walk bits, then frames; latch a new request on accept.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      frame_cnt_d = frame_cnt_q;
      result_d    = result_q;
      flags_d     = flags_q;
      err_d       = err_q;
      crc_d       = crc_q;
      is_err_d    = is_err_q;
      case (state_q)
         IDLE: begin
            bit_cnt_d   = 4'd0;
            frame_cnt_d = 3'd0;
            if (accept) state_d = FRAME;
         end
         FRAME: begin
            if (bit_cnt_q != 4'd10) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (last_frame) begin
               bit_cnt_d   = 4'd0;
               frame_cnt_d = 3'd0;
               state_d     = accept ? FRAME : IDLE;
            end else begin
               bit_cnt_d   = 4'd0;
               frame_cnt_d = frame_cnt_q + 3'd1;
`ifdef MTM_ALU_SER_GAP_EN
               state_d     = GAP;
`else
               state_d     = FRAME;
`endif
            end
         end
         GAP: begin
            if (bit_cnt_q == 4'd1) begin
               bit_cnt_d = 4'd0;
               state_d   = FRAME;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            bit_cnt_d   = 4'd0;
            frame_cnt_d = 3'd0;
         end
      endcase
      if (accept) begin
         result_d = result;
         flags_d  = flags;
         err_d    = err_flags;
         crc_d    = crc3(result, flags);
         is_err_d = start_err;
      end
   end

   // Output logic: next line bit from the next position and next latched data.
   always_comb begin
      type_bit = is_err_d || (frame_cnt_d == 3'd4);
      payload  = 8'h00;
      if (is_err_d) begin
         payload = {1'b1, err_d, err_d, ^{1'b1, err_d, err_d}};
      end else begin
         case (frame_cnt_d)
            3'd0:    payload = result_d[31:24];
            3'd1:    payload = result_d[23:16];
            3'd2:    payload = result_d[15:8];
            3'd3:    payload = result_d[7:0];
            3'd4:    payload = {1'b0, flags_d, crc_d};
            default: payload = 8'h00;
         endcase
      end
      sout_d = 1'b1;
      if (state_d == FRAME) begin
         case (bit_cnt_d)
            4'd0:    sout_d = 1'b0;
            4'd1:    sout_d = type_bit;
            4'd10:   sout_d = 1'b1;
            default: sout_d = payload[3'(4'd9 - bit_cnt_d)];
         endcase
      end
      ready_d = (state_d == IDLE);
   end

   assign sout  = sout_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: directed frames from the requirement tables
// plus randomized requests checked against a frame-level reference model.
module tb_mtm_alu_serializer;

`ifdef MTM_ALU_SER_GAP_EN
   localparam int DATA_LEN = 63;
`else
   localparam int DATA_LEN = 55;
`endif
   localparam int ERR_LEN = 11;

   logic        clk;
   logic        rst;
   logic        start_data;
   logic        start_err;
   logic [31:0] result;
   logic [3:0]  flags;
   logic [2:0]  err_flags;
   logic        ready;
   logic        sout;

   logic [0:0]  exp_q[$];
   int          n_checks;
   int          n_fail;

   mtm_alu_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .start_data (start_data),
      .start_err  (start_err),
      .result     (result),
      .flags      (flags),
      .err_flags  (err_flags),
      .ready      (ready),
      .sout       (sout)
   );

   // Clock and initial reset levels
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   // CRC as polynomial long division of msg*x^3 by x^3+x+1 (binary 1011).
   function automatic logic [2:0] crc3_ref(input logic [31:0] r, input logic [3:0] f);
      logic [39:0] v;
      v = {r, 1'b0, f, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (v[i]) v = v ^ (40'b1011 << (i - 3));
      return v[2:0];
   endfunction

   task automatic push_frame(input logic t, input logic [7:0] p);
      exp_q.push_back(1'b0);
      exp_q.push_back(t);
      for (int i = 7; i >= 0; i--) exp_q.push_back(p[i]);
      exp_q.push_back(1'b1);
   endtask

   task automatic push_gap();
`ifdef MTM_ALU_SER_GAP_EN
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
`endif
   endtask

   task automatic push_response(input logic sd, input logic se, input logic [31:0] r,
                                input logic [3:0] f, input logic [2:0] e);
      logic [6:0] hi;
      if (se) begin
         hi = {1'b1, e, e};
         push_frame(1'b1, {hi, 1'($countones(hi) % 2)});
      end else if (sd) begin
         for (int b = 3; b >= 0; b--) begin
            push_frame(1'b0, r[8*b +: 8]);
            push_gap();
         end
         push_frame(1'b1, {1'b0, f, crc3_ref(r, f)});
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_req(input logic sd, input logic se, input logic [31:0] r,
                            input logic [3:0] f, input logic [2:0] e);
      start_data = sd;
      start_err  = se;
      result     = r;
      flags      = f;
      err_flags  = e;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive_req(1'b1, 1'b1, $urandom, 4'($urandom), 3'($urandom));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (sout !== 1'b1) begin n_fail++; $display("FAIL reset_sout cycle %0d: got %b want 1", k, sout); end
         n_checks++;
         if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready cycle %0d: got %b want 1", k, ready); end
      end
      rst = 1'b0;
      drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
      @(negedge clk);
      n_checks++;
      if (sout !== 1'b1 || ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_idle: sout=%b ready=%b want 1 1", sout, ready);
      end
   endtask

   task automatic test_err_flags();
      logic [2:0] ef_tab [3];
      logic [7:0] pl_tab [3];
      logic [0:0] e;
      ef_tab = '{3'b100, 3'b010, 3'b001};
      pl_tab = '{8'b11001001, 8'b10100101, 8'b10010011};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_q.delete();
         push_frame(1'b1, pl_tab[i]);
         n_checks++;
         if (ready !== 1'b1) begin n_fail++; $display("FAIL err_pre_ready[%0d]: got %b want 1", i, ready); end
         drive_req(1'b0, 1'b1, $urandom, 4'($urandom), ef_tab[i]);
         for (int k = 1; k <= ERR_LEN; k++) begin
            @(negedge clk);
            if (k == 1) drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
            e = exp_q.pop_front();
            n_checks++;
            if (sout !== e) begin n_fail++; $display("FAIL err_frame[%0d] bit %0d: sout=%b want %b", i, k, sout, e); end
            n_checks++;
            if (ready !== 1'b0) begin n_fail++; $display("FAIL err_ready[%0d] cycle %0d: got %b want 0", i, k, ready); end
         end
         @(negedge clk);
         n_checks++;
         if (ready !== 1'b1 || sout !== 1'b1) begin
            n_fail++; $display("FAIL err_end[%0d]: ready=%b sout=%b want 1 1", i, ready, sout);
         end
      end
   endtask

   task automatic test_zero_result();
      logic [0:0] e;
      int lows;
      @(negedge clk);
      exp_q.delete();
      for (int b = 0; b < 4; b++) begin
         push_frame(1'b0, 8'h00);
         push_gap();
      end
      push_frame(1'b1, 8'b00010110);
      drive_req(1'b1, 1'b0, 32'd0, 4'b0010, 3'd0);
      lows = 0;
      for (int k = 1; k <= DATA_LEN; k++) begin
         @(negedge clk);
         if (k == 1) drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
         e = exp_q.pop_front();
         n_checks++;
         if (sout !== e) begin n_fail++; $display("FAIL zero_frame bit %0d: sout=%b want %b", k, sout, e); end
         if (ready === 1'b0) lows++;
      end
      @(negedge clk);
      if (ready === 1'b0) lows++;
      n_checks++;
      if (lows !== DATA_LEN) begin n_fail++; $display("FAIL zero_ready_len: low %0d cycles want %0d", lows, DATA_LEN); end
   endtask

   task automatic test_model_resp(input string name, input logic sd, input logic se,
                                  input logic [31:0] r, input logic [3:0] f, input logic [2:0] ef);
      logic [0:0] e;
      int len;
      @(negedge clk);
      exp_q.delete();
      push_response(sd, se, r, f, ef);
      len = exp_q.size();
      drive_req(sd, se, r, f, ef);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (k == 1) drive_req(1'b0, 1'b0, $urandom, 4'($urandom), 3'($urandom));
         e = exp_q.pop_front();
         n_checks++;
         if (sout !== e) begin n_fail++; $display("FAIL %s bit %0d: sout=%b want %b", name, k, sout, e); end
         n_checks++;
         if (ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready cycle %0d: got %b want 0", name, k, ready); end
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || sout !== 1'b1) begin
         n_fail++; $display("FAIL %s_end: ready=%b sout=%b want 1 1", name, ready, sout);
      end
   endtask

   task automatic test_random();
      logic sd, se;
      for (int i = 0; i < 8; i++) begin
         se = 1'($urandom_range(0, 2) == 0);
         sd = se ? 1'($urandom_range(0, 1)) : 1'b1;
         test_model_resp("rand_resp", sd, se, $urandom, 4'($urandom), 3'($urandom_range(1, 7)));
      end
   endtask

   task automatic test_busy();
      logic [0:0] e;
      logic [31:0] r;
      logic [3:0] f;
      int len;
      @(negedge clk);
      r = $urandom;
      f = 4'($urandom);
      exp_q.delete();
      push_response(1'b1, 1'b0, r, f, 3'd0);
      len = exp_q.size();
      drive_req(1'b1, 1'b0, r, f, 3'd0);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (sout !== e) begin n_fail++; $display("FAIL busy bit %0d: sout=%b want %b", k, sout, e); end
         if (k < len) drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 3'($urandom));
         else drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || sout !== 1'b1) begin
         n_fail++; $display("FAIL busy_end: ready=%b sout=%b want 1 1", ready, sout);
      end
   endtask

   task automatic test_reset_mid();
      logic [0:0] e;
      @(negedge clk);
      exp_q.delete();
      push_response(1'b1, 1'b0, 32'h5A3C_96E1, 4'b1010, 3'd0);
      drive_req(1'b1, 1'b0, 32'h5A3C_96E1, 4'b1010, 3'd0);
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         if (k == 1) drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
         e = exp_q.pop_front();
         n_checks++;
         if (sout !== e) begin n_fail++; $display("FAIL rstmid_pre bit %0d: sout=%b want %b", k, sout, e); end
      end
      rst = 1'b1;
      drive_req(1'b1, 1'b1, $urandom, 4'($urandom), 3'($urandom));
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (sout !== 1'b1 || ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_abort cycle %0d: sout=%b ready=%b want 1 1", k, sout, ready);
         end
      end
      rst = 1'b0;
      drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (sout !== 1'b1 || ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_idle cycle %0d: sout=%b ready=%b want 1 1", k, sout, ready);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [0:0] e;
      logic [31:0] r1, r2;
      logic [3:0] f1, f2;
      logic [2:0] ef;
      int l1, len;
      @(negedge clk);
      r1 = $urandom; f1 = 4'($urandom);
      r2 = $urandom; f2 = 4'($urandom);
      ef = 3'($urandom_range(1, 7));
      exp_q.delete();
      push_response(1'b1, 1'b0, r1, f1, 3'd0);
      l1 = exp_q.size();
      push_response(1'b0, 1'b1, 32'd0, 4'd0, ef);
      push_response(1'b1, 1'b0, r2, f2, 3'd0);
      len = exp_q.size();
      drive_req(1'b1, 1'b0, r1, f1, 3'd0);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (k == 1 || k == l1 + 1 || k == l1 + ERR_LEN + 1) drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
         e = exp_q.pop_front();
         n_checks++;
         if (sout !== e) begin n_fail++; $display("FAIL b2b bit %0d: sout=%b want %b", k, sout, e); end
         n_checks++;
         if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready cycle %0d: got %b want 0", k, ready); end
         if (k == l1) drive_req(1'b0, 1'b1, 32'd0, 4'd0, ef);
         if (k == l1 + ERR_LEN) drive_req(1'b1, 1'b0, r2, f2, 3'd0);
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || sout !== 1'b1) begin
         n_fail++; $display("FAIL b2b_end: ready=%b sout=%b want 1 1", ready, sout);
      end
   endtask

   // Test sequence and final report
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      drive_req(1'b0, 1'b0, 32'd0, 4'd0, 3'd0);
      test_reset();
      test_err_flags();
      test_zero_result();
      test_model_resp("max_result", 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b0001, 3'd0);
      test_model_resp("simultaneous", 1'b1, 1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b110);
      test_random();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mtm_alu_serializer.md
MTM_ALU_SERIALIZER -- requirements
Module: mtm_alu_serializer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start_data, input, 1 bit: request to send a result response (4 DATA frames + 1 CTL frame).
REQ-004 The block SHALL have port start_err, input, 1 bit: request to send an error response (1 CTL frame).
REQ-005 The block SHALL have port result, input, 32 bits: ALU result C, sampled on accept.
REQ-006 The block SHALL have port flags, input, 4 bits: {carry, overflow, zero, negative}, sampled on accept.
REQ-007 The block SHALL have port err_flags, input, 3 bits: {ERR_DATA, ERR_CRC, ERR_OP}, sampled on accept.
REQ-008 The block SHALL have port ready, output, 1 bit: high when a request can be accepted.
REQ-009 The block SHALL have port sout, output, 1 bit: serial line, idle high, registered.

Function
REQ-010 Accept SHALL occur at a rising edge where ready=1 and (start_data or start_err)=1; inputs latched at that edge.
REQ-011 If start_data and start_err are both high at accept, the error response SHALL be sent and the data request dropped.
REQ-012 Requests while ready=0 SHALL be ignored, without queuing.
REQ-013 Each frame SHALL be 11 bits, one bit per clk cycle: start 0, type bit (0 DATA, 1 CTL), 8 payload bits MSB first, stop 1.
REQ-014 The first bit (start) SHALL appear on sout in the cycle following the accept edge.
REQ-015 A data response SHALL send DATA payloads result[31:24], [23:16], [15:8], [7:0] in that order, then a CTL frame.
REQ-016 The data CTL payload SHALL be {1'b0, flags[3:0], crc3[2:0]}.
REQ-017 crc3 SHALL be CRC-3, polynomial x^3+x+1, init 000, computed over the 37-bit message {result, 1'b0, flags}, MSB first.
REQ-018 The error CTL payload SHALL be {1'b1, err_flags, err_flags, p}, with p chosen so the 8-bit payload has even parity.
REQ-019 The FSM SHALL have states IDLE, FRAME, GAP, with the following transitions:
- IDLE->FRAME on accept.
- FRAME->next FRAME (or GAP) after the stop bit.
- Last frame's stop bit->IDLE.
REQ-020 A 4-bit bit counter (0..10) and a 3-bit frame counter (0..4) SHALL track position; both wrap to 0 on return to IDLE.
REQ-021 ready SHALL be 0 from the accept edge until the edge ending the final stop bit, and 1 from that edge.
REQ-022 A new accept on the edge that ends the final stop bit SHALL produce the next start bit with no idle cycle.
REQ-023 sout SHALL be 1 in IDLE and GAP.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL set sout=1, ready=1, state=IDLE and both counters=0, and SHALL clear the latched data.
REQ-025 Reset mid-frame SHALL abort the response immediately; sout=1 from the next edge, with no partial-frame completion.
REQ-026 start_data and start_err SHALL be ignored in any cycle where rst=1.

Configuration
REQ-027 With macro MTM_ALU_SER_GAP_EN defined, 2 idle-high cycles (GAP) SHALL be inserted between consecutive frames of one response; a data response then lasts 63 cycles.
REQ-028 Without MTM_ALU_SER_GAP_EN, frames SHALL be back-to-back and the GAP state SHALL be unused; a data response lasts 55 cycles and an error response 11 cycles in both builds.

Verification
REQ-029 The bench SHALL cover an error response: start_err=1, err_flags=3'b100 -> sout frame 0 1 11001001 1, ready low 11 cycles.
REQ-030 The bench SHALL cover each remaining error flag:
- err_flags=3'b010 -> frame 0 1 10100101 1.
- err_flags=3'b001 -> frame 0 1 10010011 1.
REQ-031 The bench SHALL cover a zero result: start_data=1, result=0, flags=4'b0010 -> 4 frames 0 0 00000000 1, then CTL frame 0 1 00010110 1; ready low 55 cycles without GAP.
REQ-032 The bench SHALL cover a maximum result: result=32'hFFFFFFFF, flags=4'b0001 -> 4 frames 0 0 11111111 1, then a CTL frame whose CRC matches the REQ-017 reference model.
REQ-033 The bench SHALL cover simultaneous and busy requests:
- start_data=start_err=1 -> only the error frame is sent.
- start_data pulses while ready=0 -> no change to the output stream.
REQ-034 The bench SHALL cover reset and back-to-back requests:
- rst=1 during frame 2 of a data response -> sout=1 and ready=1 next edge.
- A back-to-back accept on the ready-rise edge -> contiguous stream.
